// File: rtl/gps_uart_rx.sv
// 16x oversampled UART receiver with a fractional-N tick generator and a show-ahead output FIFO.
// Define GPS_UART_RX_STATS_EN to build the saturating frame_err_count / overrun_count statistics.
module gps_uart_rx #(
   parameter int unsigned ACC_BITS        = 12,
   parameter int unsigned BAUD_ADD        = 25,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        rxd,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        frame_err,
   output logic        overrun,
   output logic [15:0] frame_err_count,
   output logic [15:0] overrun_count
);

   localparam int unsigned                DEPTH    = 1 << FIFO_DEPTH_LOG2;
   localparam logic [ACC_BITS:0]          BAUD_INC = (ACC_BITS + 1)'(BAUD_ADD);
   localparam logic [FIFO_DEPTH_LOG2:0]   PTR_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [1:0]                 sync_r;
   logic                       rxd_s;
   logic [ACC_BITS:0]          acc_r;
   logic                       tick_s;
   state_t                     state_r, state_nxt_s;
   logic [3:0]                 tick_cnt_r, cnt_nxt_s;
   logic [2:0]                 bit_idx_r, idx_nxt_s;
   logic [7:0]                 shreg_r, shreg_nxt_s;
   logic [1:0]                 smp_r, smp_nxt_s, smp_upd_s;
   logic                       push_r, push_nxt_s;
   logic                       frame_err_r, ferr_nxt_s;
   logic                       decide_s, bit_dec_s;
   logic [7:0]                 mem_r [DEPTH];
   logic [FIFO_DEPTH_LOG2:0]   wr_ptr_r, rd_ptr_r;
   logic                       empty_s, full_s, pop_s, wr_en_s, drop_s;
   logic                       overrun_r;

   assign tick_s    = acc_r[ACC_BITS];
   assign decide_s  = (tick_cnt_r == 4'd9);
   assign bit_dec_s = maj3(smp_r[0], smp_r[1], rxd_s);

   // Two-stage synchronizer plus the rxd_s register that feeds all receive logic.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         sync_r <= 2'b11;
         rxd_s  <= 1'b1;
      end else begin
         sync_r <= {sync_r[0], rxd};
         rxd_s  <= sync_r[1];
      end
   end

   // Free-running phase accumulator; the carry bit is the 16x sample tick.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         acc_r <= '0;
      end else begin
         acc_r <= {1'b0, acc_r[ACC_BITS-1:0]} + BAUD_INC;
      end
   end

   // Capture the mid-bit samples at tick counts 7 and 8; count 9 uses rxd_s directly.
   always_comb begin
      smp_upd_s = smp_r;
      case (tick_cnt_r)
         4'd7:    smp_upd_s = {smp_r[1], rxd_s};
         4'd8:    smp_upd_s = {rxd_s, smp_r[0]};
         default: smp_upd_s = smp_r;
      endcase
   end

   // Receive FSM next-state logic; everything advances only on a tick.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = tick_cnt_r;
      idx_nxt_s   = bit_idx_r;
      shreg_nxt_s = shreg_r;
      smp_nxt_s   = smp_r;
      push_nxt_s  = 1'b0;
      ferr_nxt_s  = 1'b0;
      if (tick_s) begin
         smp_nxt_s = smp_upd_s;
         case (state_r)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_nxt_s = ST_START;
                  cnt_nxt_s   = 4'd1;
               end else begin
                  cnt_nxt_s   = 4'd0;
               end
            end
            ST_START: begin
               cnt_nxt_s = tick_cnt_r + 4'd1;
               if (decide_s && bit_dec_s) begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = 4'd0;
               end else if (decide_s) begin
                  state_nxt_s = ST_DATA;
                  idx_nxt_s   = 3'd0;
               end else begin
                  state_nxt_s = ST_START;
               end
            end
            ST_DATA: begin
               cnt_nxt_s = tick_cnt_r + 4'd1;
               if (decide_s) begin
                  shreg_nxt_s = {bit_dec_s, shreg_r[7:1]};
                  if (bit_idx_r == 3'd7) begin
                     state_nxt_s = ST_STOP;
                  end else begin
                     idx_nxt_s = bit_idx_r + 3'd1;
                  end
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_STOP: begin
               cnt_nxt_s = tick_cnt_r + 4'd1;
               if (decide_s) begin
                  cnt_nxt_s = 4'd0;
                  if (bit_dec_s) begin
                     push_nxt_s  = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     ferr_nxt_s  = 1'b1;
                     state_nxt_s = ST_BREAK;
                  end
               end else begin
                  state_nxt_s = ST_STOP;
               end
            end
            ST_BREAK: begin
               cnt_nxt_s = 4'd0;
               if (rxd_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_BREAK;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Receive FSM state and datapath registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_r     <= ST_IDLE;
         tick_cnt_r  <= 4'd0;
         bit_idx_r   <= 3'd0;
         shreg_r     <= 8'h00;
         smp_r       <= 2'b11;
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         tick_cnt_r  <= cnt_nxt_s;
         bit_idx_r   <= idx_nxt_s;
         shreg_r     <= shreg_nxt_s;
         smp_r       <= smp_nxt_s;
         push_r      <= push_nxt_s;
         frame_err_r <= ferr_nxt_s;
      end
   end

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[FIFO_DEPTH_LOG2-1:0] == rd_ptr_r[FIFO_DEPTH_LOG2-1:0]) &&
                    (wr_ptr_r[FIFO_DEPTH_LOG2] != rd_ptr_r[FIFO_DEPTH_LOG2]);
   assign pop_s   = m_tvalid & m_tready;
   // A pop in the same clk frees the head slot, so a push into a full FIFO still lands.
   assign wr_en_s = push_r & (~full_s | pop_s);
   assign drop_s  = push_r & full_s & ~pop_s;

   // Output FIFO storage, pointers and sticky overrun flag.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         overrun_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r[FIFO_DEPTH_LOG2-1:0]] <= shreg_r;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (drop_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign m_tdata   = mem_r[rd_ptr_r[FIFO_DEPTH_LOG2-1:0]];
   assign m_tvalid  = ~empty_s;
   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;

`ifdef GPS_UART_RX_STATS_EN
   logic [15:0] ferr_cnt_r, ovr_cnt_r;

   // Saturating event counters.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ferr_cnt_r <= 16'h0000;
         ovr_cnt_r  <= 16'h0000;
      end else begin
         if (frame_err_r && (ferr_cnt_r != 16'hFFFF)) begin
            ferr_cnt_r <= ferr_cnt_r + 16'd1;
         end
         if (drop_s && (ovr_cnt_r != 16'hFFFF)) begin
            ovr_cnt_r <= ovr_cnt_r + 16'd1;
         end
      end
   end

   assign frame_err_count = ferr_cnt_r;
   assign overrun_count   = ovr_cnt_r;
`else
   assign frame_err_count = 16'h0000;
   assign overrun_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed bench for gps_uart_rx: single byte, glitch, framing error, overrun,
// full-FIFO push/pop collision and reset mid-frame. Runs a faster baud setting.
module tb_gps_uart_rx;

   // ACC_BITS=12, BAUD_ADD=1000: tick every 4.096 clk, bit = 65.536 clk
   localparam int BIT_CLKS = 66;

`ifdef GPS_UART_RX_STATS_EN
   localparam logic [15:0] STAT_ONE = 16'd1;
`else
   localparam logic [15:0] STAT_ONE = 16'd0;
`endif

   logic        clk      = 1'b0;
   logic        aresetn  = 1'b0;
   logic        rxd      = 1'b1;
   logic        m_tready = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        frame_err;
   logic        overrun;
   logic [15:0] frame_err_count;
   logic [15:0] overrun_count;

   int errors      = 0;
   int checks      = 0;
   int ferr_pulses = 0;
   int f0;
   bit found;

   always #5 clk = ~clk;

   gps_uart_rx #(
      .ACC_BITS        (12),
      .BAUD_ADD        (1000),
      .FIFO_DEPTH_LOG2 (4)
   ) dut (
      .clk             (clk),
      .aresetn         (aresetn),
      .rxd             (rxd),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .frame_err       (frame_err),
      .overrun         (overrun),
      .frame_err_count (frame_err_count),
      .overrun_count   (overrun_count)
   );

   // Count frame_err pulses seen on the port.
   always @(posedge clk) begin
      if (frame_err) ferr_pulses <= ferr_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_bit();
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic drive_data(input logic [7:0] d);
      rxd = 1'b0;
      wait_bit();
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_bit();
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      drive_data(d);
      rxd = 1'b1;
      wait_bit();
      wait_bit();
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d);
      chk({tag, " valid"}, {31'd0, m_tvalid}, 32'd1);
      chk({tag, " data"}, {24'd0, m_tdata}, {24'd0, d});
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " tvalid"}, {31'd0, m_tvalid}, 32'd0);
      chk({tag, " tdata"}, {24'd0, m_tdata}, 32'd0);
      chk({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
      chk({tag, " overrun"}, {31'd0, overrun}, 32'd0);
      chk({tag, " ferr_cnt"}, {16'd0, frame_err_count}, 32'd0);
      chk({tag, " ovr_cnt"}, {16'd0, overrun_count}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      aresetn = 1'b1;
      repeat (10) @(negedge clk);

      // single byte '$'
      f0 = ferr_pulses;
      send_byte(8'h24);
      pop_expect("t1", 8'h24);
      chk("t1 empty", {31'd0, m_tvalid}, 32'd0);
      chk("t1 no ferr", ferr_pulses - f0, 32'd0);
      chk("t1 overrun", {31'd0, overrun}, 32'd0);

      // short low glitch is a false start
      f0 = ferr_pulses;
      rxd = 1'b0;
      repeat (12) @(negedge clk);
      rxd = 1'b1;
      repeat (4 * BIT_CLKS) @(negedge clk);
      chk("t2 no byte", {31'd0, m_tvalid}, 32'd0);
      chk("t2 no ferr", ferr_pulses - f0, 32'd0);
      send_byte(8'h3C);
      pop_expect("t2 next", 8'h3C);

      // framing error then held-low line
      f0 = ferr_pulses;
      drive_data(8'h55);
      rxd = 1'b0;
      repeat (6) wait_bit();
      rxd = 1'b1;
      wait_bit();
      wait_bit();
      chk("t3 ferr pulses", ferr_pulses - f0, 32'd1);
      chk("t3 no byte", {31'd0, m_tvalid}, 32'd0);
      chk("t3 ferr_cnt", {16'd0, frame_err_count}, {16'd0, STAT_ONE});
      send_byte(8'hA5);
      pop_expect("t3 next", 8'hA5);
      chk("t3 empty", {31'd0, m_tvalid}, 32'd0);

      // overrun with consumer stalled
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      chk("t4 full valid", {31'd0, m_tvalid}, 32'd1);
      chk("t4 no overrun yet", {31'd0, overrun}, 32'd0);
      send_byte(8'h10);
      chk("t4 overrun", {31'd0, overrun}, 32'd1);
      chk("t4 ovr_cnt", {16'd0, overrun_count}, {16'd0, STAT_ONE});
      for (int i = 0; i < 16; i++) pop_expect("t4 drain", 8'(i));
      chk("t4 drained", {31'd0, m_tvalid}, 32'd0);

      // full FIFO, push and pop in the same clk
      aresetn = 1'b0;
      @(negedge clk);
      chk("t5 reset overrun", {31'd0, overrun}, 32'd0);
      aresetn = 1'b1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
      chk("t5 head", {24'd0, m_tdata}, 32'h80);
      drive_data(8'h90);
      rxd = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 4 * BIT_CLKS && !found; k++) begin
         @(negedge clk);
         if (dut.push_r) found = 1'b1;
      end
      chk("t5 push seen", {31'd0, found}, 32'd1);
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
      wait_bit();
      wait_bit();
      chk("t5 no overrun", {31'd0, overrun}, 32'd0);
      chk("t5 ovr_cnt", {16'd0, overrun_count}, 32'd0);
      for (int i = 0; i < 16; i++) pop_expect("t5 drain", 8'h81 + 8'(i));
      chk("t5 drained", {31'd0, m_tvalid}, 32'd0);

      // reset during data bit 4
      send_byte(8'h33);
      chk("t6 pre valid", {31'd0, m_tvalid}, 32'd1);
      rxd = 1'b0;
      wait_bit();
      for (int i = 0; i < 4; i++) wait_bit();
      rxd = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      aresetn = 1'b0;
      #1;
      chk_reset_vals("t6 in reset");
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
      repeat (6) wait_bit();
      chk("t6 no byte", {31'd0, m_tvalid}, 32'd0);
      send_byte(8'h0D);
      pop_expect("t6 next", 8'h0D);
      chk("t6 empty", {31'd0, m_tvalid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gps_uart_rx.md
# gps_uart_rx

Oversampled UART receiver that snoops the GPS serial line (GPS_RX) in the PL, alongside the PS UART that owns it. It converts the receive line into a byte stream for PL-side consumers such as the NMEA/PPS time-tagging logic. A fractional-N phase accumulator generates the 16x sample tick, with the same scheme as the debug baud counters. Received bytes are buffered in a small FIFO with a valid/ready output.

## Interface
Parameters:
- ACC_BITS, 12: tick accumulator fraction width. The tick is the carry out of bit ACC_BITS.
- BAUD_ADD, 25: accumulator increment per clk. The defaults give 16x of roughly 38400 baud from 100 MHz.
- FIFO_DEPTH_LOG2, 4: output FIFO depth is 2^FIFO_DEPTH_LOG2 (default 16).

Ports:
- clk, input, 1: the single clock (pl_clk0 domain).
- aresetn, input, 1: reset, asynchronous assert, active-low. Release is synchronous to clk.
- rxd, input, 1: raw asynchronous serial line, idle high.
- m_tdata, output, 8: received byte.
- m_tvalid, output, 1: m_tdata is valid.
- m_tready, input, 1: consumer accepts the byte.
- frame_err, output, 1: one-clk pulse when a stop bit is sampled low.
- overrun, output, 1: sticky; a byte was dropped because the FIFO was full. Cleared only by reset.
- frame_err_count, output, 16: saturating count of framing errors (present only with the macro, see Configuration).
- overrun_count, output, 16: saturating count of dropped bytes (present only with the macro).

## Operation
- **Input synchronizer:** rxd passes through a 2-FF synchronizer. The register after it, rxd_s, drives all logic. Reset value is 1.
- **Tick generator:**
  - acc[ACC_BITS:0] <= acc[ACC_BITS-1:0] + BAUD_ADD every clk.
  - tick = acc[ACC_BITS], so it is high for exactly one clk per carry.
  - The accumulator free-runs; it is not phase-aligned to the start bit.
- **Sampling:**
  - A 4-bit tick_cnt counts ticks within the current bit.
  - Samples are taken at tick_cnt = 7, 8 and 9.
  - The bit value is the majority of the three samples, decided on the tick where tick_cnt = 9.
- **State machine:**
  - IDLE: tick_cnt held at 0. On any tick with rxd_s = 0, go to START with tick_cnt = 1.
  - START: count ticks. At the tick_cnt = 9 decision:
    - majority 1: false start, return to IDLE;
    - majority 0: go to DATA with bit_idx = 0.
  - DATA:
    - Each bit ends on the tick where tick_cnt wraps 15 to 0; tick_cnt keeps running from the start bit.
    - The decided bit is shifted into shreg[7] with a right shift (LSB first).
    - After bit_idx = 7, go to STOP.
  - STOP: at the decision point:
    - majority 1: push shreg into the FIFO, return to IDLE;
    - majority 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxd_s = 1 on a tick, then go to IDLE. This covers a held-low line.
- **FIFO:**
  - Pointers are FIFO_DEPTH_LOG2+1 bits wide.
  - empty when the pointers are equal.
  - full when the addresses are equal and the MSBs differ.
- **Push when full:** the new byte is dropped, overrun is set, and overrun_count increments.
- **Output:**
  - Show-ahead: m_tdata is the FIFO head and m_tvalid = !empty.
  - A pop happens when m_tvalid && m_tready.
- **Simultaneous push and pop:**
  - Both are allowed in the same clk.
  - A push into a full FIFO in the same clk as a pop succeeds; no overrun.
- **Reset values:**
  - state = IDLE, acc = 0, FIFO empty;
  - m_tvalid = 0, m_tdata = 0;
  - frame_err = 0, overrun = 0, all counters 0.
- **Reset mid-frame:** any partial byte is lost and the FIFO contents are discarded.

## Timing
- rxd to rxd_s: 3 clk.
- Falling-edge detection resolution: one tick period, about 164 clk at the defaults.
- STOP decision tick to FIFO write: 1 clk. Write to m_tvalid high when the FIFO was empty: 1 clk.
- frame_err is asserted in the clk after the STOP decision tick.
- m_tvalid/m_tdata hold steady until accepted. A new head appears the clk after a pop.
- Counters update in the clk after the event and saturate at 0xFFFF.

## Configuration
- With `GPS_UART_RX_STATS_EN` defined:
  - frame_err_count and overrun_count exist and count as described above.
- Without it:
  - both ports still exist but are tied to 0;
  - no counter registers are synthesized;
  - frame_err and overrun are unaffected.

## Test plan
1. **Single byte:** clk 100 MHz, defaults, bit period 16×4096/25 ≈ 2621 clk. Drive 0x24 ('$') with one stop bit. Expect m_tdata = 0x24 with m_tvalid, no frame_err, and overrun = 0.
2. **Glitch rejection:** drive a 300-clk low pulse on an idle line. Expect return to IDLE from START, no FIFO write, and no frame_err.
3. **Framing error:** drive 0x55 with the stop bit low, then hold the line low for 5 bit periods, then release. Expect one frame_err pulse, frame_err_count = 1 (macro on), no byte output, and the next byte 0xA5 received correctly.
4. **Overrun:** hold m_tready = 0 and send 17 bytes 0x00..0x10. Expect a full FIFO, overrun = 1 and overrun_count = 1. Draining then yields exactly 0x00..0x0F.
5. **Full FIFO with simultaneous push and pop:** with the FIFO full, assert m_tready for one clk coincident with the FIFO write. Expect no overrun and occupancy remains 16.
6. **Reset mid-frame:** assert aresetn low during data bit 4, then release before the line idles. Expect m_tvalid = 0 and all outputs at their reset values. The following clean byte 0x0D is received.
